seg7_display_arbiter: RTL and testbench

- Shares the single 4-digit multiplexed 7-segment display between four requesters (camera status, colour-classifier result, solver step counter, debug).
- Round-robin arbitration with a programmable dwell time per source.
- Registered 16-bit hex word drives the scanning display driver's digit input.
- Grant vector tells each requester when its value is being shown.

---
 rtl/seg7_display_arbiter.sv | 167 ++++++++++++++++
 tb/tb_seg7_display_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit multiplexed 7-segment display between four requesters.
// Define SEG7_ARB_BLANK_EN to insert a BLANK_CYCLES blank gap between different sources.
module seg7_display_arbiter #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_CYCLES = 2500000,
  parameter int CNT_W        = 32
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic [3:0]  iREQ,
  input  logic [15:0] iDATA0,
  input  logic [15:0] iDATA1,
  input  logic [15:0] iDATA2,
  input  logic [15:0] iDATA3,
  input  logic        iLOCK,
  output logic [15:0] oDIG,
  output logic [3:0]  oGNT,
  output logic [1:0]  oSRC,
  output logic        oVALID
);

`ifdef SEG7_ARB_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;
  localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2 || BLANK_CYCLES < 1) begin : g_bad_param
    $error("seg7_display_arbiter: DWELL_CYCLES must be >= 2 and BLANK_CYCLES >= 1");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       last, last_nxt;
  logic [15:0]      dig_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       src_nxt;
  logic             vld_nxt;

  logic [15:0] data [4];
  assign data[0] = iDATA0;
  assign data[1] = iDATA1;
  assign data[2] = iDATA2;
  assign data[3] = iDATA3;

  // Returns {found, index} of the first requester after 'from', wrapping 3->0 and ending at 'from'.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick_last, pick_cur;
  logic       others;
  logic       do_grant, do_clear;
  logic [1:0] grant_idx;

  // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    dig_nxt   = oDIG;
    gnt_nxt   = oGNT;
    src_nxt   = oSRC;
    vld_nxt   = oVALID;
    do_grant  = 1'b0;
    do_clear  = 1'b0;
    grant_idx = 2'd0;
    pick_last = rr_pick(iREQ, last);
    pick_cur  = rr_pick(iREQ, oSRC);
    others    = |(iREQ & ~oGNT);

    case (state)
      IDLE: begin
        if (pick_last[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_last[1:0];
        end
      end
      SHOW: begin
        dig_nxt = data[oSRC];
        // A dropped request ends the grant at once; otherwise only an unlocked expiry rotates.
        if (!iREQ[oSRC] || (!iLOCK && cnt == '0 && others)) begin
          last_nxt = oSRC;
          if (!pick_cur[2]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            do_clear  = 1'b1;
          end else begin
`ifdef SEG7_ARB_BLANK_EN
            state_nxt = BLANK;
            cnt_nxt   = BLANK_RELOAD;
            do_clear  = 1'b1;
`else
            do_grant  = 1'b1;
            grant_idx = pick_cur[1:0];
`endif
          end
        end else if (!iLOCK) begin
          cnt_nxt = (cnt == '0) ? DWELL_RELOAD : cnt - CNT_W'(1);
        end
      end
`ifdef SEG7_ARB_BLANK_EN
      BLANK: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else if (pick_last[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_last[1:0];
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        do_clear  = 1'b1;
      end
    endcase

    if (do_grant) begin
      state_nxt = SHOW;
      cnt_nxt   = DWELL_RELOAD;
      src_nxt   = grant_idx;
      gnt_nxt   = 4'b0001 << grant_idx;
      vld_nxt   = 1'b1;
      dig_nxt   = data[grant_idx];
    end else if (do_clear) begin
      src_nxt   = 2'd0;
      gnt_nxt   = 4'b0000;
      vld_nxt   = 1'b0;
      dig_nxt   = 16'h0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= 2'd3;
      oDIG   <= 16'h0000;
      oGNT   <= 4'b0000;
      oSRC   <= 2'd0;
      oVALID <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      last   <= last_nxt;
      oDIG   <= dig_nxt;
      oGNT   <= gnt_nxt;
      oSRC   <= src_nxt;
      oVALID <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Self-checking bench for seg7_display_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of who owns the display and for how long.
module tb_seg7_display_arbiter;
  localparam int DWELL = 8;
  localparam int BLANK = 4;

  logic        iCLK = 1'b0;
  logic        iRST_n;
  logic [3:0]  iREQ;
  logic [15:0] iDATA0, iDATA1, iDATA2, iDATA3;
  logic        iLOCK;
  logic [15:0] oDIG;
  logic [3:0]  oGNT;
  logic [1:0]  oSRC;
  logic        oVALID;

  seg7_display_arbiter #(
    .DWELL_CYCLES(DWELL),
    .BLANK_CYCLES(BLANK),
    .CNT_W(8)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iREQ(iREQ),
    .iDATA0(iDATA0), .iDATA1(iDATA1), .iDATA2(iDATA2), .iDATA3(iDATA3),
    .iLOCK(iLOCK), .oDIG(oDIG), .oGNT(oGNT), .oSRC(oSRC), .oVALID(oVALID)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_cur is the source on the display (-1 = none), m_left the cycles it still has after this one.
  int  m_cur, m_left, m_last;
  bit  m_blank;

  function automatic int pick(input logic [3:0] req, input int from);
    for (int k = 1; k <= 4; k++)
      if (req[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] data_of(input int s);
    case (s)
      0: return iDATA0;
      1: return iDATA1;
      2: return iDATA2;
      default: return iDATA3;
    endcase
  endfunction

  task automatic model_reset();
    m_cur = -1; m_left = 0; m_last = 3; m_blank = 0;
  endtask

  task automatic show(input int s);
    m_cur = s; m_left = DWELL - 1; m_blank = 0;
  endtask

  task automatic leave_current();
    int w;
    m_last = m_cur;
    w = pick(iREQ, m_last);
    m_cur = -1;
    if (w >= 0) begin
`ifdef SEG7_ARB_BLANK_EN
      m_blank = 1; m_left = BLANK - 1;
`else
      show(w);
`endif
    end
  endtask

  task automatic model_step();
    int w;
    if (m_blank) begin
      if (m_left > 0) m_left--;
      else begin
        m_blank = 0;
        w = pick(iREQ, m_last);
        if (w >= 0) show(w);
      end
    end else if (m_cur < 0) begin
      w = pick(iREQ, m_last);
      if (w >= 0) show(w);
    end else if (!iREQ[m_cur]) begin
      leave_current();
    end else if (!iLOCK) begin
      if (m_left > 0) m_left--;
      else if ((iREQ & ~(4'b0001 << m_cur)) != 4'b0000) leave_current();
      else m_left = DWELL - 1;
    end
  endtask

  task automatic compare();
    logic [15:0] e_dig;
    logic [3:0]  e_gnt;
    e_dig = (m_cur >= 0) ? data_of(m_cur) : 16'h0000;
    e_gnt = (m_cur >= 0) ? 4'(4'b0001 << m_cur) : 4'b0000;
    check("oVALID", 32'(oVALID), 32'(m_cur >= 0));
    check("oGNT",   32'(oGNT),   32'(e_gnt));
    check("oSRC",   32'(oSRC),   (m_cur >= 0) ? 32'(m_cur) : 32'd0);
    check("oDIG",   32'(oDIG),   32'(e_dig));
  endtask

  // Model advances with the inputs present at the edge; outputs are sampled on the falling edge.
  task automatic tick();
    if (!iRST_n) model_reset();
    else model_step();
    @(posedge iCLK);
    @(negedge iCLK);
    compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    iRST_n = 1'b0; iREQ = 4'b1111; iLOCK = 1'b0;
    iDATA0 = 16'h0A0A; iDATA1 = 16'h1B1B; iDATA2 = 16'h2C2C; iDATA3 = 16'h3D3D;
    model_reset();
    ticks(3);
    check("reset_gnt", 32'(oGNT), 32'd0);

    iRST_n = 1'b1;
    tick();
    check("first_gnt", 32'(oGNT), 32'b0001);
    ticks(40);

    iREQ = 4'b0100; iDATA2 = 16'h1234;
    ticks(20);
    check("sole_gnt", 32'(oGNT), 32'b0100);
    check("sole_dig", 32'(oDIG), 32'h1234);
    iDATA2 = 16'hBEEF;
    tick();
    check("beef_dig", 32'(oDIG), 32'hBEEF);

    iREQ = 4'b0010;
    ticks(12);
    iREQ = 4'b1010;
    ticks(3);
    iREQ = 4'b1000;
    tick();
`ifndef SEG7_ARB_BLANK_EN
    check("drop_gnt", 32'(oGNT), 32'b1000);
`endif
    iREQ = 4'b0000;
    tick();
    check("idle_vld", 32'(oVALID), 32'd0);
    iREQ = 4'b0001;
    tick();
    check("regrant_gnt", 32'(oGNT), 32'b0001);

    iREQ = 4'b1111; iLOCK = 1'b1;
    ticks(20);
    check("lock_gnt", 32'(oGNT), 32'b0001);
    iLOCK = 1'b0;
    ticks(7);
    check("unlock_hold", 32'(oGNT), 32'b0001);
    ticks(1);
`ifndef SEG7_ARB_BLANK_EN
    check("unlock_adv", 32'(oGNT), 32'b0010);
`endif
    ticks(10);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) iREQ = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) iLOCK = ~iLOCK;
      if ($urandom_range(0, 3) == 0) iDATA0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) iDATA1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) iDATA2 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) iDATA3 = 16'($urandom);
      tick();
    end

    iLOCK = 1'b0; iREQ = 4'b0011;
`ifdef SEG7_ARB_BLANK_EN
    for (int i = 0; i < 100 && !m_blank; i++) tick();
    check("reached_blank", 32'(m_blank), 32'd1);
`else
    ticks(5);
`endif
    #2 iRST_n = 1'b0;
    #1;
    model_reset();
    check("arst_vld", 32'(oVALID), 32'd0);
    check("arst_gnt", 32'(oGNT), 32'd0);
    check("arst_src", 32'(oSRC), 32'd0);
    check("arst_dig", 32'(oDIG), 32'd0);
    @(negedge iCLK);
    tick();
    iRST_n = 1'b1;
    tick();
    check("post_rst_gnt", 32'(oGNT), 32'b0001);
    ticks(60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
